// File: rtl/rom_load_buffer.sv
// Buffers ROM programmer byte writes in a small FIFO and commits them to PRG/CHR
// memory one byte per cycle while the NES core grants the memory ports.
module rom_load_buffer #(
   parameter int DEPTH  = 8,
   parameter int PRG_AW = 15,
   parameter int CHR_AW = 13
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [15:0]       ROM_ADDR,
   input  logic [7:0]        TO_ROM,
   input  logic              WRITE_ROM,
   input  logic              LOAD_EN,
   output logic [PRG_AW-1:0] PRG_ADDR,
   output logic [7:0]        PRG_DATA,
   output logic              PRG_WE,
   output logic [CHR_AW-1:0] CHR_ADDR,
   output logic [7:0]        CHR_DATA,
   output logic              CHR_WE,
   output logic              FULL,
   output logic              OVERFLOW,
   output logic              BAD_ADDR,
   output logic [15:0]       BYTE_COUNT,
   output logic              DBG_STATE
);

   // Handshake: a push is the rising edge of WRITE_ROM; a pop happens on any
   // edge where LOAD_EN=1 and the FIFO holds data, and its WE pulse follows.
   localparam int PW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t        state, state_next;
   logic [23:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count, count_next;
   logic          wr_prev;
   logic          push_req, is_prg, is_chr, addr_ok;
   logic          empty, full_now, push, pop, drop, bad;
   logic [23:0]   entry_in, head;

   always_comb begin
      push_req   = WRITE_ROM & ~wr_prev;
      is_prg     = ~ROM_ADDR[15];
      is_chr     = (ROM_ADDR[15:13] == 3'b100);
      addr_ok    = is_prg | is_chr;
      empty      = (count == '0);
      full_now   = (count == (PW+1)'(DEPTH));
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (LOAD_EN && !empty) begin
               state_next = DRAIN;
               pop        = 1'b1;
            end
         end
         DRAIN: begin
            if (LOAD_EN && !empty) pop = 1'b1;
            else                   state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A simultaneous pop frees a slot, so a push into a full FIFO is kept.
      push       = push_req & addr_ok & (~full_now | pop);
      drop       = push_req & addr_ok & full_now & ~pop;
      bad        = push_req & ~addr_ok;
      count_next = count + (PW+1)'(push) - (PW+1)'(pop);
      entry_in   = is_prg ? {1'b0, ROM_ADDR[14:0], TO_ROM}
                          : {1'b1, 2'b00, ROM_ADDR[12:0], TO_ROM};
      head       = mem[rd_ptr];
   end

   assign DBG_STATE = (state == DRAIN);

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= entry_in;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state      <= IDLE;
         wr_prev    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         FULL       <= 1'b0;
         OVERFLOW   <= 1'b0;
         BAD_ADDR   <= 1'b0;
         BYTE_COUNT <= '0;
         PRG_ADDR   <= '0;
         PRG_DATA   <= '0;
         PRG_WE     <= 1'b0;
         CHR_ADDR   <= '0;
         CHR_DATA   <= '0;
         CHR_WE     <= 1'b0;
      end else begin
         state   <= state_next;
         wr_prev <= WRITE_ROM;
         count   <= count_next;
         FULL    <= (count_next == (PW+1)'(DEPTH));
         PRG_WE  <= 1'b0;
         CHR_WE  <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (drop) OVERFLOW <= 1'b1;
         if (bad)  BAD_ADDR <= 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (BYTE_COUNT != 16'hFFFF) BYTE_COUNT <= BYTE_COUNT + 16'd1;
            if (head[23]) begin
               CHR_ADDR <= head[CHR_AW+7:8];
               CHR_DATA <= head[7:0];
               CHR_WE   <= 1'b1;
            end else begin
               PRG_ADDR <= head[PRG_AW+7:8];
               PRG_DATA <= head[7:0];
               PRG_WE   <= 1'b1;
            end
         end
      end
   end

endmodule
